// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store front end for a word-wide RAM
// with one-cycle registered read. Sub-word stores are read-modify-write.
module mem_access_unit #(
    // Byte-address width shared with the RAM (RAM_ADDRESS_BITWIDTH in the SoC build)
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write_data,
    input  logic [31:0]       ram_data
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       merge_q, merge_d;

    logic              req_err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    // Misalignment / illegal width decode on the incoming request
    always_comb begin
        req_err = 1'b1;
        if (req_we) begin
            case (req_funct3)
                3'd0:    req_err = 1'b0;
                3'd1:    req_err = req_addr[0];
                3'd2:    req_err = |req_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: req_err = 1'b0;
                3'd1, 3'd5: req_err = req_addr[0];
                3'd2:       req_err = |req_addr[1:0];
                default:    req_err = 1'b1;
            endcase
        end
    end

    // Lane select and sign/zero extension of the captured RAM word
    always_comb begin
        byte_sel = ram_data[{addr_q[1:0], 3'b000} +: 8];
        half_sel = ram_data[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_ext = {24'd0, byte_sel};
            3'd5:    load_ext = {16'd0, half_sel};
            default: load_ext = ram_data;
        endcase
    end

    // Merge store lane into the read word; untouched lanes keep their old value
    always_comb begin
        merged = ram_data;
        if (f3_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    // Next-state logic; response fields only change on the edge into RESP
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (req_we && req_funct3 == 3'd2) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (we_q) begin
                    merge_d = merged;
                    state_d = WR;
                end else begin
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WR: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_err       = err_q;
    assign resp_rdata     = rdata_q;
    assign ram_wren       = (state_q == WR);
    assign ram_address    = {addr_q[ADDR_W-1:2], 2'b00};
    // SW writes the latched store word directly; SB/SH write the merged word
    assign ram_write_data = (state_q == WR && f3_q[1]) ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized + directed check against a word-array model.
module tb_mem_access_unit;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          ram_wren;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_write_data;
    logic [31:0]   ram_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          we;
        logic [2:0]    f3;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ram_wren(ram_wren), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read
    always @(posedge clk) begin
        ram_data <= mem[ram_address[AW-1:2]];
        if (ram_wren) mem[ram_address[AW-1:2]] <= ram_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what the access must do, from width/alignment rules
    task automatic model(input req_t r, output logic err, output logic [31:0] rdata,
                         output logic [31:0] wword, output int lat, output int wr_off);
        int sz, a;
        logic legal;
        logic [31:0] w, v, mask;
        a  = int'(r.addr[1:0]);
        w  = ref_mem[r.addr[AW-1:2]];
        sz = (r.f3[1:0] == 2'd0) ? 1 : (r.f3[1:0] == 2'd1) ? 2 : 4;
        legal = r.we ? (r.f3 <= 3'd2) : (r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err    = !legal || (a % sz != 0);
        rdata  = 32'd0;
        wword  = w;
        lat    = 1;
        wr_off = 0;
        if (!err) begin
            if (!r.we) begin
                lat  = 3;
                mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
                v    = (w >> (8 * a)) & mask;
                if (r.f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
                rdata = v;
            end else begin
                for (int i = 0; i < sz; i++) wword[8 * (a + i) +: 8] = r.wdata[8 * i +: 8];
                lat    = (sz == 4) ? 2 : 4;
                wr_off = lat - 1;
            end
        end
    endtask

    task automatic drive(input logic v, input req_t r);
        req_valid  = v;
        req_we     = r.we;
        req_funct3 = r.f3;
        req_addr   = r.addr;
        req_wdata  = r.wdata;
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.we    = 1'($urandom % 2);
        r.f3    = 3'($urandom % 8);
        r.addr  = AW'($urandom_range(0, 31));
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic req_t mk(input logic we, input logic [2:0] f3,
                                input logic [AW-1:0] addr, input logic [31:0] wd);
        req_t r;
        r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wd;
        return r;
    endfunction

    // Issue one request from an IDLE cycle (#1 after an edge) and compare every
    // cycle until the idle cycle following RESP. During busy cycles the inputs
    // carry nxt (valid only if nxt_v) to show they are ignored until IDLE.
    task automatic run(input req_t r, input logic lit_en, input logic [31:0] lit,
                       input logic nxt_v, input req_t nxt);
        logic err;
        logic [31:0] rdata, wword;
        int lat, wr_off;
        model(r, err, rdata, wword, lat, wr_off);
        chk("ready_idle", 32'(req_ready), 32'd1);
        drive(1'b1, r);
        @(posedge clk); #1;
        drive(nxt_v, nxt);
        for (int k = 1; k <= lat; k++) begin
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("resp_valid", 32'(resp_valid), 32'(k == lat));
            chk("ram_wren", 32'(ram_wren), 32'(k == wr_off));
            if (k == 1 && !err)
                chk("ram_address", 32'(ram_address), 32'({r.addr[AW-1:2], 2'b00}));
            if (k == wr_off) begin
                chk("wr_address", 32'(ram_address), 32'({r.addr[AW-1:2], 2'b00}));
                chk("wr_data", ram_write_data, wword);
                if (lit_en) chk("wr_data_lit", ram_write_data, lit);
                ref_mem[r.addr[AW-1:2]] = wword;
            end
            if (k == lat) begin
                chk("resp_err", 32'(resp_err), 32'(err));
                chk("resp_rdata", resp_rdata, rdata);
                if (lit_en && (!r.we || err)) chk("rdata_lit", resp_rdata, lit);
            end
            @(posedge clk); #1;
        end
        chk("valid_after", 32'(resp_valid), 32'd0);
        chk("err_held", 32'(resp_err), 32'(err));
        chk("rdata_held", resp_rdata, rdata);
    endtask

    req_t none, q[$];

    initial begin
        none = mk(1'b0, 3'd0, '0, 32'd0);
        rst = 1'b1;
        drive(1'b0, none);
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_wdata", ram_write_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-computed expectations
        run(mk(1, 3'd2, 8'h10, 32'hDEADBEEF), 1, 32'hDEADBEEF, 0, none);
        run(mk(0, 3'd0, 8'h13, 32'h0), 1, 32'hFFFFFFDE, 0, none);
        run(mk(0, 3'd4, 8'h13, 32'h0), 1, 32'h000000DE, 0, none);
        run(mk(0, 3'd1, 8'h10, 32'h0), 1, 32'hFFFFBEEF, 0, none);
        run(mk(0, 3'd5, 8'h12, 32'h0), 1, 32'h0000DEAD, 0, none);
        run(mk(1, 3'd0, 8'h11, 32'h12345677), 1, 32'hDEAD77EF, 0, none);
        run(mk(0, 3'd2, 8'h10, 32'h0), 1, 32'hDEAD77EF, 0, none);
        run(mk(1, 3'd2, 8'h20, 32'h0), 1, 32'h00000000, 0, none);
        run(mk(1, 3'd1, 8'h22, 32'hAAAA5555), 1, 32'h55550000, 0, none);
        run(mk(0, 3'd2, 8'h12, 32'h0), 1, 32'h0, 0, none);
        run(mk(1, 3'd1, 8'h11, 32'h0), 1, 32'h0, 0, none);
        run(mk(0, 3'd6, 8'h10, 32'h0), 1, 32'h0, 0, none);

        // Reset during CAP of an SB aborts it; request held during reset is ignored
        drive(1'b1, mk(1, 3'd0, 8'h10, 32'h000000FF));
        @(posedge clk); #1;
        drive(1'b0, none);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, mk(1, 3'd2, 8'h30, 32'h12345678));
        @(posedge clk); #1;
        chk("abort_wren", 32'(ram_wren), 32'd0);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        chk("abort_err", 32'(resp_err), 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk("abort_addr", 32'(ram_address), 32'd0);
        chk("abort_wdata", ram_write_data, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_hold_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        drive(1'b0, none);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_wren", 32'(ram_wren), 32'd0);
            chk("post_rst_valid", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        run(mk(0, 3'd2, 8'h10, 32'h0), 1, 32'hDEAD77EF, 0, none);
        run(mk(0, 3'd2, 8'h30, 32'h0), 0, 32'h0, 0, none);

        // Random traffic; next request sometimes held valid through the busy phase
        for (int i = 0; i < 300; i++) q.push_back(rnd_req());
        for (int i = 0; i < 300; i++) begin
            if (i < 299 && ($urandom % 2) == 1) run(q[i], 0, 32'h0, 1, q[i + 1]);
            else run(q[i], 0, 32'h0, 0, rnd_req());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end placed directly upstream of the word-wide data RAM. It accepts one memory request at a time from the execute stage and drives the RAM's `wren`/`address`/`write_data` ports, accounting for the RAM's one-cycle registered read latency. It returns sign- or zero-extended load data. Byte and halfword stores are done as a read-modify-write, since the RAM has no byte enables.

## Interface
- `ADDR_W`, default `RAM_ADDRESS_BITWIDTH` (from `include/define.v`): byte-address width shared with the RAM.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V width code. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data; the low bits are used for SB/SH.
- `resp_valid` out 1: one-cycle completion pulse. There is no back-pressure.
- `resp_err` out 1: misaligned access or illegal funct3; qualified by `resp_valid`.
- `resp_rdata` out 32: extended load data; 0 for stores and for errors.
- `ram_wren` out 1: RAM write enable.
- `ram_address` out ADDR_W: word-aligned byte address, bits [1:0] always 0.
- `ram_write_data` out 32: full word to write.
- `ram_data` in 32: RAM read data. It is valid the cycle after `ram_address` is presented.

## Operation
- Handshake:
  - A request is accepted when `req_valid & req_ready`.
  - All request fields are latched at acceptance.
  - Inputs are ignored in every other state.
- State machine states: IDLE, RD, CAP, WR, RESP.
- Transitions out of IDLE on acceptance:
  - Error → RESP.
  - Load → RD.
  - SW → WR.
  - SB/SH → RD.
- Remaining transitions:
  - RD → CAP.
  - CAP → RESP for a load; CAP → WR for SB/SH.
  - WR → RESP.
  - RESP → IDLE.
- Error conditions (no RAM access, `ram_wren` stays 0):
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 greater than 2.
- `ram_address` is always {addr_q[ADDR_W-1:2], 2'b00}, driven from the latched address.
- Lanes are little-endian: byte k = bits [8k+7:8k]; halfword at addr[1]=h = bits [16h+15:16h].
- CAP, load:
  - Select the byte or halfword lane from `ram_data`.
  - Sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word unchanged.
  - Register the result into `resp_rdata`.
- CAP, SB/SH:
  - Merge `wdata_q[7:0]` or `wdata_q[15:0]` into the addressed lane of `ram_data`.
  - All other lanes keep their read value.
  - Register the merged word into `ram_write_data`.
- SW: `ram_write_data` = `wdata_q` in WR.
- `ram_wren` = 1 only in WR, for exactly one cycle per store.
- `resp_valid` = 1 only in RESP. `resp_err` and `resp_rdata` are held from RESP until the next RESP.

## Timing
Request accepted at edge of cycle N:
- Error: `resp_valid` in N+1.
- SW: `ram_wren` in N+1; `resp_valid` in N+2.
- Load: `ram_address` presented in N+1; `ram_data` sampled in N+2; `resp_valid` and data in N+3.
- SB/SH: read in N+1, merge in N+2, `ram_wren` in N+3, `resp_valid` in N+4.

Throughput and reset:
- The next request can be accepted no earlier than the cycle after RESP.
- Reset values: state IDLE; `req_ready`=1; `resp_valid`, `resp_err`, `ram_wren` = 0; `resp_rdata`, `ram_address`, `ram_write_data` = 0.
- Reset asserted in any state, including mid-RMW (RD/CAP/WR), aborts the operation. No write is issued after the reset edge, and no `resp_valid` is produced for the aborted request.
- `req_valid` asserted during reset is not accepted.
- `req_valid` held high while busy is not accepted until IDLE; it is then accepted once.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF → `ram_wren`=1 in N+1 with address 0x10 and data 0xDEADBEEF; `resp_valid` in N+2 with err=0.
- RAM word at 0x10 = 0xDEADBEEF:
  - LB 0x13 → `resp_rdata` 0xFFFFFFDE at N+3.
  - LBU 0x13 → 0x000000DE.
  - LH 0x10 → 0xFFFFBEEF.
  - LHU 0x12 → 0x0000DEAD.
- Word 0x10 = 0xDEADBEEF, SB 0x11 with wdata 0x12345677 → one write in N+3 of 0xDEAD77EF; a following LW 0x10 returns 0xDEAD77EF.
- SH 0x12 with wdata 0xAAAA5555 onto 0x00000000 → write of 0x55550000 in N+3; `resp_valid` in N+4.
- LW 0x12, SH 0x11, load funct3=6 → `resp_valid` in N+1 with err=1, rdata 0, no `ram_wren`.
- `rst` pulsed during CAP of SB → no `ram_wren`, no `resp_valid`, all outputs 0; `req_ready`=1 on the next cycle and a new LW completes normally.
